// File: rtl/coax_rx_buffer_if.sv
// coax_rx_buffer_if: coax_rx side strobes plus host pop/error side of the receive buffer.
// The level signal exists only when COAX_RX_BUFFER_LEVEL_EN is defined.
interface coax_rx_buffer_if #(
   parameter int DEPTH_BITS = 4
);
   logic [9:0] rx_data;
   logic       rx_data_available;
   logic       rx_error;
   logic       rx_read;
   logic       rx_reset;
   logic [9:0] data;
   logic       empty;
   logic       full;
   logic       read;
   logic       error;
   logic [9:0] error_code;
   logic       clear_error;
`ifdef COAX_RX_BUFFER_LEVEL_EN
   logic [DEPTH_BITS:0] level;
`endif

   modport slave (
      input  rx_data, rx_data_available, rx_error, read, clear_error,
`ifdef COAX_RX_BUFFER_LEVEL_EN
      output level,
`endif
      output rx_read, rx_reset, data, empty, full, error, error_code
   );

   modport master (
      output rx_data, rx_data_available, rx_error, read, clear_error,
`ifdef COAX_RX_BUFFER_LEVEL_EN
      input  level,
`endif
      input  rx_read, rx_reset, data, empty, full, error, error_code
   );
endinterface

// File: rtl/coax_rx_buffer.sv
// coax_rx_buffer: drains coax_rx into a DEPTH-entry FIFO (0-cycle head read); full leaves words in coax_rx.
// Sticky error capture with host-commanded coax_rx reset; COAX_RX_BUFFER_LEVEL_EN adds an occupancy output.
module coax_rx_buffer #(
   parameter int DEPTH      = 16,
   parameter int DEPTH_BITS = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   coax_rx_buffer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      POP     = 3'd1,
      SETTLE  = 3'd2,
      ERROR   = 3'd3,
      RECOVER = 3'd4
   } state_t;

   state_t              state_q;
   logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
   logic [9:0]          mem_q [DEPTH];
   logic                rx_read_q;
   logic                rx_reset_q;
   logic                error_q;
   logic [9:0]          error_code_q;
   logic                empty;
   logic                full;
   logic                push;
   logic                pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                  (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);

   // full is from registered pointers, so a same-cycle host pop cannot admit a write.
   assign push = (state_q == IDLE) && !bus.rx_error && bus.rx_data_available && !full;
   assign pop  = bus.read && !empty;

   assign wr_ptr_d = wr_ptr_q + (DEPTH_BITS + 1)'(push);
   assign rd_ptr_d = rd_ptr_q + (DEPTH_BITS + 1)'(pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= bus.rx_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rx_read_q    <= 1'b0;
         rx_reset_q   <= 1'b0;
         error_q      <= 1'b0;
         error_code_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.rx_error) begin
                  state_q      <= ERROR;
                  error_q      <= 1'b1;
                  error_code_q <= bus.rx_data;
               end else if (push) begin
                  state_q   <= POP;
                  rx_read_q <= 1'b1;
               end
            end
            POP: begin
               state_q   <= SETTLE;
               rx_read_q <= 1'b0;
            end
            // coax_rx needs a cycle to drop data_available after the strobe.
            SETTLE: begin
               state_q <= IDLE;
            end
            ERROR: begin
               if (bus.clear_error) begin
                  state_q      <= RECOVER;
                  error_q      <= 1'b0;
                  error_code_q <= '0;
                  rx_reset_q   <= 1'b1;
               end
            end
            RECOVER: begin
               state_q    <= IDLE;
               rx_reset_q <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               rx_read_q  <= 1'b0;
               rx_reset_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef COAX_RX_BUFFER_LEVEL_EN
   logic [DEPTH_BITS:0] level_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= '0;
      end else begin
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   assign bus.level = level_q;
`endif

   assign bus.data       = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];
   assign bus.empty      = empty;
   assign bus.full       = full;
   assign bus.rx_read    = rx_read_q;
   assign bus.rx_reset   = rx_reset_q;
   assign bus.error      = error_q;
   assign bus.error_code = error_code_q;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// tb_coax_rx_buffer: directed vector table, multi-cycle corner sequences and random traffic,
// all checked against a transaction-level model (word queue plus accept-cooldown counter).
module tb_coax_rx_buffer;

   localparam int DEPTH = 16;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   coax_rx_buffer_if bus();

   coax_rx_buffer #(.DEPTH(DEPTH), .DEPTH_BITS(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;

   // reference model: FIFO contents, cycles before a new word may be taken, error status
   bit [9:0] m_q[$];
   int       m_busy;
   bit       m_err;
   bit [9:0] m_code;
   bit       m_rd;
   bit       m_rst;

   // emulated coax_rx: pending words and error condition
   bit [9:0] src_q[$];
   bit       err_drv;
   bit [9:0] err_val;

   typedef struct {
      bit       add;
      bit [9:0] word;
      bit       rd;
      bit       clr;
      bit       err;
      bit [9:0] code;
      bit       e_rx_read;
      bit       e_rx_reset;
      bit       e_empty;
      bit       e_error;
      bit [9:0] e_code;
      bit [9:0] e_data;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_src();
      bus.rx_error          = err_drv;
      bus.rx_data_available = (src_q.size() != 0);
      if (err_drv)                bus.rx_data = err_val;
      else if (src_q.size() != 0) bus.rx_data = src_q[0];
      else                        bus.rx_data = 10'h000;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_busy = 0;
      m_err  = 1'b0;
      m_code = 10'h000;
      m_rd   = 1'b0;
      m_rst  = 1'b0;
   endtask

   task automatic model_step();
      bit do_pop;
      bit do_push;
      do_pop  = bus.read && (m_q.size() > 0);
      do_push = 1'b0;
      m_rd    = 1'b0;
      m_rst   = 1'b0;
      if (m_busy > 0) begin
         m_busy--;
      end else if (m_err) begin
         if (bus.clear_error) begin
            m_err  = 1'b0;
            m_code = 10'h000;
            m_busy = 1;
            m_rst  = 1'b1;
         end
      end else if (bus.rx_error) begin
         m_err  = 1'b1;
         m_code = bus.rx_data;
      end else if (bus.rx_data_available && m_q.size() < DEPTH) begin
         do_push = 1'b1;
         m_busy  = 2;
         m_rd    = 1'b1;
      end
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(bus.rx_data);
   endtask

   task automatic check_all();
      chk("empty",      32'(bus.empty),      32'(m_q.size() == 0));
      chk("full",       32'(bus.full),       32'(m_q.size() == DEPTH));
      chk("rx_read",    32'(bus.rx_read),    32'(m_rd));
      chk("rx_reset",   32'(bus.rx_reset),   32'(m_rst));
      chk("error",      32'(bus.error),      32'(m_err));
      chk("error_code", 32'(bus.error_code), 32'(m_code));
      if (m_q.size() != 0) chk("data", 32'(bus.data), 32'(m_q[0]));
`ifdef COAX_RX_BUFFER_LEVEL_EN
      chk("level", 32'(bus.level), 32'(m_q.size()));
`endif
   endtask

   // one clock: model sees the pre-edge inputs, DUT outputs are compared 1 time unit after the edge
   task automatic tick();
      bit src_pop;
      bit ext_rst;
      model_step();
      src_pop = bus.rx_read;
      ext_rst = bus.rx_reset;
      @(posedge clk);
      #1;
      if (src_pop && src_q.size() != 0) void'(src_q.pop_front());
      if (ext_rst) err_drv = 1'b0;
      bus.read        = 1'b0;
      bus.clear_error = 1'b0;
      drive_src();
      check_all();
   endtask

   task automatic async_reset_check(input string tag);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk({tag, "_empty"},    32'(bus.empty),    32'd1);
      chk({tag, "_full"},     32'(bus.full),     32'd0);
      chk({tag, "_error"},    32'(bus.error),    32'd0);
      chk({tag, "_rx_read"},  32'(bus.rx_read),  32'd0);
      chk({tag, "_rx_reset"}, 32'(bus.rx_reset), 32'd0);
      model_reset();
      src_q.delete();
      err_drv = 1'b0;
      drive_src();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      vec_t     vecs[15];
      bit [9:0] got[$];
      int       n;
      bit       seen;

      bus.read        = 1'b0;
      bus.clear_error = 1'b0;
      err_drv         = 1'b0;
      err_val         = 10'h000;
      model_reset();
      drive_src();

      //                add  word    rd clr err code     rxr rxs emp err ecode   data
      vecs[0]  = '{1'b1, 10'h1B3, 0, 0, 0, 10'h000,  1, 0, 0, 0, 10'h000, 10'h1B3};
      vecs[1]  = '{1'b0, 10'h000, 0, 0, 0, 10'h000,  0, 0, 0, 0, 10'h000, 10'h1B3};
      vecs[2]  = '{1'b0, 10'h000, 0, 0, 0, 10'h000,  0, 0, 0, 0, 10'h000, 10'h1B3};
      vecs[3]  = '{1'b0, 10'h000, 1, 1, 0, 10'h000,  0, 0, 1, 0, 10'h000, 10'h000};
      vecs[4]  = '{1'b1, 10'h055, 0, 0, 0, 10'h000,  1, 0, 0, 0, 10'h000, 10'h055};
      vecs[5]  = '{1'b1, 10'h0AA, 0, 0, 0, 10'h000,  0, 0, 0, 0, 10'h000, 10'h055};
      vecs[6]  = '{1'b0, 10'h000, 0, 0, 0, 10'h000,  0, 0, 0, 0, 10'h000, 10'h055};
      vecs[7]  = '{1'b0, 10'h000, 0, 0, 0, 10'h000,  1, 0, 0, 0, 10'h000, 10'h055};
      vecs[8]  = '{1'b0, 10'h000, 0, 0, 1, 10'h3FF,  0, 0, 0, 0, 10'h000, 10'h055};
      vecs[9]  = '{1'b0, 10'h000, 0, 0, 1, 10'h3FF,  0, 0, 0, 0, 10'h000, 10'h055};
      vecs[10] = '{1'b0, 10'h000, 0, 0, 1, 10'h3FF,  0, 0, 0, 1, 10'h3FF, 10'h055};
      vecs[11] = '{1'b0, 10'h000, 1, 0, 1, 10'h3FF,  0, 0, 0, 1, 10'h3FF, 10'h0AA};
      vecs[12] = '{1'b0, 10'h000, 0, 1, 1, 10'h3FF,  0, 1, 0, 0, 10'h000, 10'h0AA};
      vecs[13] = '{1'b0, 10'h000, 0, 0, 0, 10'h000,  0, 0, 0, 0, 10'h000, 10'h0AA};
      vecs[14] = '{1'b0, 10'h000, 1, 0, 0, 10'h000,  0, 0, 1, 0, 10'h000, 10'h000};

      // reset held from time zero
      #12;
      chk("rst_empty",      32'(bus.empty),      32'd1);
      chk("rst_full",       32'(bus.full),       32'd0);
      chk("rst_error",      32'(bus.error),      32'd0);
      chk("rst_error_code", 32'(bus.error_code), 32'd0);
      chk("rst_rx_read",    32'(bus.rx_read),    32'd0);
      chk("rst_rx_reset",   32'(bus.rx_reset),   32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // directed table: single word, clear_error outside ERROR, error with two buffered words
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].add) src_q.push_back(vecs[i].word);
         err_drv         = vecs[i].err;
         err_val         = vecs[i].code;
         bus.read        = vecs[i].rd;
         bus.clear_error = vecs[i].clr;
         drive_src();
         tick();
         chk($sformatf("vec%0d_rx_read", i),  32'(bus.rx_read),    32'(vecs[i].e_rx_read));
         chk($sformatf("vec%0d_rx_reset", i), 32'(bus.rx_reset),   32'(vecs[i].e_rx_reset));
         chk($sformatf("vec%0d_empty", i),    32'(bus.empty),      32'(vecs[i].e_empty));
         chk($sformatf("vec%0d_error", i),    32'(bus.error),      32'(vecs[i].e_error));
         chk($sformatf("vec%0d_code", i),     32'(bus.error_code), 32'(vecs[i].e_code));
         if (!vecs[i].e_empty)
            chk($sformatf("vec%0d_data", i),  32'(bus.data),       32'(vecs[i].e_data));
      end

      // fill: 17 words offered with the host idle
      for (int w = 1; w <= 17; w++) src_q.push_back(10'(w));
      drive_src();
      n = 0;
      while (m_q.size() < DEPTH && n < 100) begin tick(); n++; end
      chk("fill_in_time", 32'(n < 100), 32'd1);
      chk("fill_full", 32'(bus.full), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin tick(); if (bus.rx_read) seen = 1'b1; end
      chk("fill_no_17th_pop", 32'(seen), 32'd0);
      chk("fill_17th_waiting", 32'(src_q.size()), 32'd1);
      bus.read = 1'b1;
      tick();
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin tick(); if (bus.rx_read) seen = 1'b1; end
      chk("fill_17th_popped", 32'(seen), 32'd1);
      got.delete();
      n = 0;
      while ((m_q.size() != 0 || src_q.size() != 0) && n < 200) begin
         bus.read = 1'b1;
         if (!bus.empty) got.push_back(bus.data);
         tick();
         n++;
      end
      chk("drain_count", 32'(got.size()), 32'd16);
      for (int k = 0; k < got.size() && k < 16; k++)
         chk($sformatf("drain_word%0d", k), 32'(got[k]), 32'(k + 2));

      // async reset mid-operation with words buffered and a strobe in flight
      for (int w = 0; w < 3; w++) src_q.push_back(10'(10'h200 + w));
      drive_src();
      for (int k = 0; k < 4; k++) tick();
      async_reset_check("midrst");

      // simultaneous accept and host pop with 3 words held
      for (int w = 0; w < 3; w++) src_q.push_back(10'(10'h100 + w));
      drive_src();
      n = 0;
      while (!(m_q.size() == 3 && m_busy == 0 && src_q.size() == 0) && n < 50) begin tick(); n++; end
      chk("simul_setup_in_time", 32'(n < 50), 32'd1);
      src_q.push_back(10'h103);
      drive_src();
      bus.read = 1'b1;
      tick();
      chk("simul_accepted", 32'(bus.rx_read), 32'd1);
`ifdef COAX_RX_BUFFER_LEVEL_EN
      chk("simul_level", 32'(bus.level), 32'd3);
`endif
      got.delete();
      n = 0;
      while ((m_q.size() != 0 || src_q.size() != 0) && n < 50) begin
         bus.read = 1'b1;
         if (!bus.empty) got.push_back(bus.data);
         tick();
         n++;
      end
      chk("simul_count", 32'(got.size()), 32'd3);
      for (int k = 0; k < got.size() && k < 3; k++)
         chk($sformatf("simul_word%0d", k), 32'(got[k]), 32'(10'h101 + k));

      // wrap: 40 words through the 16-entry FIFO with a random host
      for (int w = 0; w < 40; w++) src_q.push_back(10'(10'h040 + w));
      drive_src();
      got.delete();
      n = 0;
      while ((m_q.size() != 0 || src_q.size() != 0) && n < 600) begin
         bus.read = ($urandom_range(3) == 0);
         if (bus.read && !bus.empty) got.push_back(bus.data);
         tick();
         n++;
      end
      chk("wrap_count", 32'(got.size()), 32'd40);
      for (int k = 0; k < got.size() && k < 40; k++)
         chk($sformatf("wrap_word%0d", k), 32'(got[k]), 32'(10'h040 + k));

      // random traffic with error injection; a slow host first so the FIFO reaches full
      for (int i = 0; i < 1600; i++) begin
         if ($urandom_range(2) == 0 && src_q.size() < 3) begin
            src_q.push_back(10'($urandom_range(1023)));
         end
         if (!err_drv && $urandom_range(149) == 0) begin
            err_drv = 1'b1;
            err_val = 10'($urandom_range(1023));
         end
         bus.read        = (i < 800) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 0);
         bus.clear_error = ($urandom_range(5) == 0);
         drive_src();
         tick();
      end

      async_reset_check("endrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
